// File: rtl/boton_evento.sv
// rtl/boton_evento.sv - button event classifier (press/short/long/repeat/release pulses)
//
// Purpose:
//   Takes the debounced, clk-synchronous button level and classifies each press
//   into single-cycle event pulses for the menu/action FSM downstream.
//
// Parameters:
//   LONG_COUNT    hold cycles from press_pulse to long_pulse (>= 2)
//   REPEAT_COUNT  cycles between repeat_pulse while in LONG (>= 2)
//   REPEAT_EN     1: emit repeat_pulse while held after long; 0: never
//   ACTIVE_LOW    1: btn_lvl==0 means pressed; 0: btn_lvl==1 means pressed
//
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous, active-low reset
//   btn_lvl        in   debounced button level, synchronous to clk
//   en             in   event enable; 0 forces IDLE and suppresses all pulses
//   press_pulse    out  1-cycle pulse on press detection
//   short_pulse    out  1-cycle pulse on release before LONG_COUNT
//   long_pulse     out  1-cycle pulse when the hold reaches LONG_COUNT
//   repeat_pulse   out  1-cycle pulse every REPEAT_COUNT cycles while in LONG
//   release_pulse  out  1-cycle pulse on release from PRESS or LONG
//   holding        out  level, 1 while in PRESS or LONG

module boton_evento #(
   parameter int unsigned LONG_COUNT   = 50_000_000,
   parameter int unsigned REPEAT_COUNT = 12_500_000,
   parameter bit          REPEAT_EN    = 1'b1,
   parameter bit          ACTIVE_LOW   = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_lvl,
   input  logic en,
   output logic press_pulse,
   output logic short_pulse,
   output logic long_pulse,
   output logic repeat_pulse,
   output logic release_pulse,
   output logic holding
);

   localparam int unsigned MAX_COUNT = (LONG_COUNT > REPEAT_COUNT) ? LONG_COUNT : REPEAT_COUNT;
   localparam int unsigned CNT_W     = $clog2(MAX_COUNT);

   localparam logic [CNT_W-1:0] LONG_TERM   = CNT_W'(LONG_COUNT - 1);
   localparam logic [CNT_W-1:0] REPEAT_TERM = CNT_W'(REPEAT_COUNT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(MAX_COUNT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS,
      ST_LONG,
      ST_WAIT_REL
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             en_q;
   logic             pressed;

   logic press_d, short_d, long_d, repeat_d, release_d, holding_d;

   // Polarity normalisation only; the debouncer already synchronised the level.
   assign pressed = btn_lvl ^ ACTIVE_LOW;

   // Saturating increment so the counter never wraps (matters with REPEAT_EN=0).
   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      short_d   = 1'b0;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      release_d = 1'b0;

      if (!en) begin
         // Disabled: drop silently to IDLE, no release event.
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               cnt_d = '0;
               if (pressed) begin
                  if (!en_q) begin
                     // Enable just rose with the button already down: that
                     // press started while disabled, so ignore it entirely.
                     state_d = ST_WAIT_REL;
                  end else begin
                     state_d = ST_PRESS;
                     press_d = 1'b1;
                  end
               end
            end

            ST_PRESS: begin
               // Release takes priority over reaching the long threshold.
               if (!pressed) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  short_d   = 1'b1;
                  release_d = 1'b1;
               end else if (cnt_q == LONG_TERM) begin
                  state_d = ST_LONG;
                  cnt_d   = '0;
                  long_d  = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            ST_LONG: begin
               if (!pressed) begin
                  state_d   = ST_IDLE;
                  cnt_d     = '0;
                  release_d = 1'b1;
               end else if (REPEAT_EN && (cnt_q == REPEAT_TERM)) begin
                  cnt_d    = '0;
                  repeat_d = 1'b1;
               end else begin
                  cnt_d = cnt_inc;
               end
            end

            ST_WAIT_REL: begin
               cnt_d = '0;
               if (!pressed) begin
                  state_d = ST_IDLE;
               end
            end

            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      // holding is registered from the next state so it lines up with state_q.
      holding_d = (state_d == ST_PRESS) || (state_d == ST_LONG);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         // Treated as "already enabled" so a button held through reset is
         // classified as a fresh press rather than parked in WAIT_REL.
         en_q          <= 1'b1;
         press_pulse   <= 1'b0;
         short_pulse   <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
         release_pulse <= 1'b0;
         holding       <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         en_q          <= en;
         press_pulse   <= press_d;
         short_pulse   <= short_d;
         long_pulse    <= long_d;
         repeat_pulse  <= repeat_d;
         release_pulse <= release_d;
         holding       <= holding_d;
      end
   end

endmodule

// File: tb/tb_boton_evento.sv
// tb/tb_boton_evento.sv - table-driven self-checking bench for boton_evento

module tb_boton_evento;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic btn_lvl = 1'b0;
   logic btn_al = 1'b1;
   logic en = 1'b1;

   logic m_press, m_short, m_long, m_rep, m_rel, m_hold;
   logic a_press, a_short, a_long, a_rep, a_rel, a_hold;

   always #5 clk = ~clk;

   boton_evento #(
      .LONG_COUNT(8), .REPEAT_COUNT(4), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b0)
   ) dut (
      .clk(clk), .reset(reset), .btn_lvl(btn_lvl), .en(en),
      .press_pulse(m_press), .short_pulse(m_short), .long_pulse(m_long),
      .repeat_pulse(m_rep), .release_pulse(m_rel), .holding(m_hold)
   );

   boton_evento #(
      .LONG_COUNT(8), .REPEAT_COUNT(4), .REPEAT_EN(1'b1), .ACTIVE_LOW(1'b1)
   ) dut_al (
      .clk(clk), .reset(reset), .btn_lvl(btn_al), .en(en),
      .press_pulse(a_press), .short_pulse(a_short), .long_pulse(a_long),
      .repeat_pulse(a_rep), .release_pulse(a_rel), .holding(a_hold)
   );

   // Output vector order: {press, short, long, repeat, release, holding}
   localparam logic [5:0] O_NONE  = 6'b000000;
   localparam logic [5:0] O_PRESS = 6'b100001;
   localparam logic [5:0] O_HOLD  = 6'b000001;
   localparam logic [5:0] O_SHORT = 6'b010010;
   localparam logic [5:0] O_LONG  = 6'b001001;
   localparam logic [5:0] O_REP   = 6'b000101;
   localparam logic [5:0] O_REL   = 6'b000010;

   typedef struct {
      logic       btn;
      logic       en;
      logic [5:0] exp;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [5:0] out_m();
      return {m_press, m_short, m_long, m_rep, m_rel, m_hold};
   endfunction

   function automatic logic [5:0] out_a();
      return {a_press, a_short, a_long, a_rep, a_rel, a_hold};
   endfunction

   function automatic void add(input int n, input logic b, input logic e, input logic [5:0] x);
      vec_t v;
      v.btn = b;
      v.en  = e;
      v.exp = x;
      for (int k = 0; k < n; k++) vecs.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [5:0] act, input logic [5:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b (press,short,long,rep,rel,hold)", nm, act, exp);
      end
   endtask

   // One clock: drive inputs, let the edge happen, sample 1 time unit later.
   task automatic step(input logic b, input logic bal, input logic e,
                       input logic [5:0] exp_m, input logic [5:0] exp_a, input string nm);
      btn_lvl = b;
      btn_al  = bal;
      en      = e;
      @(posedge clk);
      #1;
      check({nm, " main"}, out_m(), exp_m);
      check({nm, " al"}, out_a(), exp_a);
   endtask

   initial begin
      // Idle lead-in
      add(2, 1'b0, 1'b1, O_NONE);
      // Short press: 3 cycles high
      add(1, 1'b1, 1'b1, O_PRESS);
      add(2, 1'b1, 1'b1, O_HOLD);
      add(1, 1'b0, 1'b1, O_SHORT);
      add(1, 1'b0, 1'b1, O_NONE);
      // Long press with repeats: 20 cycles high
      add(1, 1'b1, 1'b1, O_PRESS);
      add(7, 1'b1, 1'b1, O_HOLD);
      add(1, 1'b1, 1'b1, O_LONG);
      add(3, 1'b1, 1'b1, O_HOLD);
      add(1, 1'b1, 1'b1, O_REP);
      add(3, 1'b1, 1'b1, O_HOLD);
      add(1, 1'b1, 1'b1, O_REP);
      add(3, 1'b1, 1'b1, O_HOLD);
      add(1, 1'b0, 1'b1, O_REL);
      add(1, 1'b0, 1'b1, O_NONE);
      // Release on the cycle the counter sits at LONG_COUNT-1
      add(1, 1'b1, 1'b1, O_PRESS);
      add(7, 1'b1, 1'b1, O_HOLD);
      add(1, 1'b0, 1'b1, O_SHORT);
      add(1, 1'b0, 1'b1, O_NONE);
      // Held while disabled, then enabled while still held: no events
      add(3, 1'b1, 1'b0, O_NONE);
      add(12, 1'b1, 1'b1, O_NONE);
      add(1, 1'b0, 1'b1, O_NONE);
      add(1, 1'b1, 1'b1, O_PRESS);
      add(1, 1'b0, 1'b1, O_SHORT);
      add(1, 1'b0, 1'b1, O_NONE);
      // Disable mid-press: silent drop to IDLE, no release_pulse
      add(1, 1'b1, 1'b1, O_PRESS);
      add(1, 1'b1, 1'b1, O_HOLD);
      add(2, 1'b1, 1'b0, O_NONE);
      add(1, 1'b0, 1'b1, O_NONE);

      // Reset state
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("reset main", out_m(), O_NONE);
      check("reset al", out_a(), O_NONE);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].btn, 1'b1, vecs[i].en, vecs[i].exp, O_NONE, $sformatf("tbl[%0d]", i));
      end

      // Asynchronous reset in LONG, button held through it
      step(1'b1, 1'b1, 1'b1, O_PRESS, O_NONE, "rst_seq press");
      for (int i = 0; i < 7; i++) step(1'b1, 1'b1, 1'b1, O_HOLD, O_NONE, $sformatf("rst_seq hold%0d", i));
      step(1'b1, 1'b1, 1'b1, O_LONG, O_NONE, "rst_seq long");
      step(1'b1, 1'b1, 1'b1, O_HOLD, O_NONE, "rst_seq inlong");
      #1;
      reset = 1'b0;
      #1;
      check("async_reset immediate", out_m(), O_NONE);
      @(posedge clk);
      #1;
      check("async_reset held", out_m(), O_NONE);
      @(negedge clk);
      reset = 1'b1;
      step(1'b1, 1'b1, 1'b1, O_PRESS, O_NONE, "post_reset press");
      step(1'b1, 1'b1, 1'b1, O_HOLD, O_NONE, "post_reset hold");
      step(1'b0, 1'b1, 1'b1, O_SHORT, O_NONE, "post_reset short");

      // Active-low instance
      step(1'b0, 1'b1, 1'b1, O_NONE, O_NONE, "al idle");
      step(1'b0, 1'b0, 1'b1, O_NONE, O_PRESS, "al press");
      step(1'b0, 1'b0, 1'b1, O_NONE, O_HOLD, "al hold");
      step(1'b0, 1'b1, 1'b1, O_NONE, O_SHORT, "al short");
      step(1'b0, 1'b1, 1'b1, O_NONE, O_NONE, "al after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete, got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
